// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register plus writeback stage.
//
// Registers the memory-cycle results, then extracts and extends load data
// (LB/LH/LW/LBU/LHU), picks the register-file write value (load data,
// PC+4 link, or ALU result) and drives the register-file write port, which
// also feeds the forwarding unit.
//
// Optional build macro: RETIRE_COUNTER_EN adds a 64-bit retired-instruction
// counter on output InstretW.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   StallW, FlushW       hold / bubble the MEM/WB register (flush wins)
//   ValidM .. WriteAddressM  memory-cycle instruction fields
//   RegWriteEnW          register-file write enable
//   WriteAddressW        register-file write address
//   WriteDataW           register-file write data / forwarding value
//   ValidW               a valid instruction occupies WB
//   LoadMisalignW        sticky misaligned-load flag
//   InstretW             retired-instruction count (RETIRE_COUNTER_EN only)
module mem_wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  StallW,
  input  logic                  FlushW,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic                  MemReadM,
  input  logic                  JtypeM,
  input  logic [2:0]            Funct3M,
  input  logic [XLEN-1:0]       ALUOutM,
  input  logic [XLEN-1:0]       DataMemOutM,
  input  logic [XLEN-1:0]       PCPlus4M,
  input  logic [REG_ADDR_W-1:0] WriteAddressM,
  output logic                  RegWriteEnW,
  output logic [REG_ADDR_W-1:0] WriteAddressW,
  output logic [XLEN-1:0]       WriteDataW,
  output logic                  ValidW,
  output logic                  LoadMisalignW
`ifdef RETIRE_COUNTER_EN
  ,
  output logic [63:0]           InstretW
`endif
);

  logic                  validQ, regWriteQ, memReadQ, jtypeQ;
  logic [2:0]            funct3Q;
  logic [XLEN-1:0]       aluOutQ, memDataQ, pcPlus4Q;
  logic [REG_ADDR_W-1:0] rdQ;
  logic                  misalignStickyQ;

  logic [7:0]            byteSel;
  logic [15:0]           halfSel;
  logic [XLEN-1:0]       loadData;
  logic                  addrMisalign;
  logic                  curMisalign;

  // MEM/WB register. Flush clears the data fields too so a bubble always
  // presents WriteDataW=0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      validQ          <= 1'b0;
      regWriteQ       <= 1'b0;
      memReadQ        <= 1'b0;
      jtypeQ          <= 1'b0;
      funct3Q         <= '0;
      aluOutQ         <= '0;
      memDataQ        <= '0;
      pcPlus4Q        <= '0;
      rdQ             <= '0;
      misalignStickyQ <= 1'b0;
    end else begin
      if (FlushW) begin
        validQ    <= 1'b0;
        regWriteQ <= 1'b0;
        memReadQ  <= 1'b0;
        jtypeQ    <= 1'b0;
        funct3Q   <= '0;
        aluOutQ   <= '0;
        memDataQ  <= '0;
        pcPlus4Q  <= '0;
        rdQ       <= '0;
      end else if (!StallW) begin
        validQ    <= ValidM;
        regWriteQ <= RegWriteM;
        memReadQ  <= MemReadM;
        jtypeQ    <= JtypeM;
        funct3Q   <= Funct3M;
        aluOutQ   <= ALUOutM;
        memDataQ  <= DataMemOutM;
        pcPlus4Q  <= PCPlus4M;
        rdQ       <= WriteAddressM;
      end
      // The live flag covers the cycle the load sits in WB; this register
      // keeps it asserted afterwards.
      if (curMisalign) misalignStickyQ <= 1'b1;
    end
  end

  // Load extraction from the registered word. Unknown funct3 behaves as LW.
  always_comb begin
    byteSel = 8'h00;
    case (aluOutQ[1:0])
      2'd0: byteSel = memDataQ[7:0];
      2'd1: byteSel = memDataQ[15:8];
      2'd2: byteSel = memDataQ[23:16];
      2'd3: byteSel = memDataQ[31:24];
      default: byteSel = 8'h00;
    endcase
    halfSel      = aluOutQ[1] ? memDataQ[31:16] : memDataQ[15:0];
    loadData     = memDataQ;
    addrMisalign = 1'b0;
    case (funct3Q)
      3'b000: loadData = {{(XLEN-8){byteSel[7]}}, byteSel};
      3'b100: loadData = {{(XLEN-8){1'b0}}, byteSel};
      3'b001: begin
        loadData     = {{(XLEN-16){halfSel[15]}}, halfSel};
        addrMisalign = aluOutQ[0];
      end
      3'b101: begin
        loadData     = {{(XLEN-16){1'b0}}, halfSel};
        addrMisalign = aluOutQ[0];
      end
      default: begin
        loadData     = memDataQ;
        addrMisalign = |aluOutQ[1:0];
      end
    endcase
  end

  assign curMisalign = validQ & memReadQ & addrMisalign;

  // Load beats link beats ALU result; data is driven even when not writing.
  assign WriteDataW    = memReadQ ? loadData : (jtypeQ ? pcPlus4Q : aluOutQ);
  assign RegWriteEnW   = validQ & regWriteQ & (rdQ != '0) & ~curMisalign;
  assign WriteAddressW = rdQ;
  assign ValidW        = validQ;
  assign LoadMisalignW = misalignStickyQ | curMisalign;

`ifdef RETIRE_COUNTER_EN
  // An instruction retires when it leaves WB: either the register advances
  // (no stall) or a flush overrides the stall and replaces it with a bubble.
  logic [63:0] instretQ;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               instretQ <= '0;
    else if (validQ && (!StallW || FlushW))   instretQ <= instretQ + 64'd1;
  end
  assign InstretW = instretQ;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed plus randomized check of mem_wb_stage against a
// record-level model of "the instruction currently in WB".
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rstN;
  logic        StallW, FlushW, ValidM, RegWriteM, MemReadM, JtypeM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUOutM, DataMemOutM, PCPlus4M;
  logic [4:0]  WriteAddressM;
  logic        RegWriteEnW, ValidW, LoadMisalignW;
  logic [4:0]  WriteAddressW;
  logic [31:0] WriteDataW;
`ifdef RETIRE_COUNTER_EN
  logic [63:0] InstretW;
`endif

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(rstN), .StallW(StallW), .FlushW(FlushW),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemReadM(MemReadM),
    .JtypeM(JtypeM), .Funct3M(Funct3M), .ALUOutM(ALUOutM),
    .DataMemOutM(DataMemOutM), .PCPlus4M(PCPlus4M),
    .WriteAddressM(WriteAddressM), .RegWriteEnW(RegWriteEnW),
    .WriteAddressW(WriteAddressW), .WriteDataW(WriteDataW),
    .ValidW(ValidW), .LoadMisalignW(LoadMisalignW)
`ifdef RETIRE_COUNTER_EN
    , .InstretW(InstretW)
`endif
  );

  typedef struct {
    logic        valid, regWrite, memRead, jtype;
    logic [2:0]  f3;
    logic [31:0] alu, dat, pc;
    logic [4:0]  rd;
  } wbRec_t;

  wbRec_t      wbM;
  logic        stickyM;
  logic [63:0] retM;
  int          nChk = 0;
  int          nPass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChk++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic wbRec_t bubble();
    wbRec_t r;
    r.valid = 0; r.regWrite = 0; r.memRead = 0; r.jtype = 0;
    r.f3 = 0; r.alu = 0; r.dat = 0; r.pc = 0; r.rd = 0;
    return r;
  endfunction

  // Value a load of type f3 at address a returns from memory word d.
  function automatic logic [31:0] loadVal(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] d);
    logic [31:0] v;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (d >> ((a % 4) * 8)) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (d >> (((a % 4) / 2) * 16)) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else v = d;
    return v;
  endfunction

  function automatic logic misal(input wbRec_t w);
    if (!(w.valid && w.memRead)) return 1'b0;
    if (w.f3 == 3'd0 || w.f3 == 3'd4) return 1'b0;
    if (w.f3 == 3'd1 || w.f3 == 3'd5) return (w.alu % 2) != 0;
    return (w.alu % 4) != 0;
  endfunction

  function automatic logic [31:0] expData(input wbRec_t w);
    if (w.memRead) return loadVal(w.f3, w.alu, w.dat);
    if (w.jtype)   return w.pc;
    return w.alu;
  endfunction

  function automatic logic expWe(input wbRec_t w);
    return w.valid && w.regWrite && (w.rd != 0) && !misal(w);
  endfunction

  task automatic checkAll(input string tag);
    chk({tag, ".valid"}, ValidW, wbM.valid);
    chk({tag, ".we"},    RegWriteEnW, expWe(wbM));
    chk({tag, ".addr"},  WriteAddressW, wbM.rd);
    chk({tag, ".data"},  WriteDataW, expData(wbM));
    chk({tag, ".misal"}, LoadMisalignW, stickyM | misal(wbM));
`ifdef RETIRE_COUNTER_EN
    chk({tag, ".instret"}, InstretW, retM);
`endif
  endtask

  // Model of one rising edge, using the inputs currently applied.
  task automatic modelEdge();
    if (misal(wbM)) stickyM = 1'b1;
    if (wbM.valid && (!StallW || FlushW)) retM = retM + 64'd1;
    if (FlushW) wbM = bubble();
    else if (!StallW) begin
      wbM.valid = ValidM; wbM.regWrite = RegWriteM; wbM.memRead = MemReadM;
      wbM.jtype = JtypeM; wbM.f3 = Funct3M; wbM.alu = ALUOutM;
      wbM.dat = DataMemOutM; wbM.pc = PCPlus4M; wbM.rd = WriteAddressM;
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll(tag);
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic jt,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] dat,
                       input logic [31:0] pc, input logic [4:0] rd,
                       input logic st, input logic fl);
    ValidM = v; RegWriteM = rw; MemReadM = mr; JtypeM = jt; Funct3M = f3;
    ALUOutM = alu; DataMemOutM = dat; PCPlus4M = pc; WriteAddressM = rd;
    StallW = st; FlushW = fl;
  endtask

  task automatic resetModel();
    wbM = bubble(); stickyM = 1'b0; retM = '0;
  endtask

  initial begin
    logic [2:0] f3Tab [6];
    f3Tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
    rstN = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetModel();
    #2;
    chk("rst.valid", ValidW, 1'b0);
    chk("rst.we",    RegWriteEnW, 1'b0);
    chk("rst.addr",  WriteAddressW, 5'd0);
    chk("rst.data",  WriteDataW, 32'd0);
    chk("rst.misal", LoadMisalignW, 1'b0);
    @(negedge clk);
    rstN = 1'b1;

    // LB / LBU from byte lane 1
    drive(1, 1, 1, 0, 3'b000, 32'h1001, 32'h1234F678, 0, 5, 0, 0);
    cycle("lb");
    chk("lb.dataC", WriteDataW, 32'hFFFFFFF6);
    chk("lb.weC", RegWriteEnW, 1'b1);
    chk("lb.addrC", WriteAddressW, 5'd5);
    drive(1, 1, 1, 0, 3'b100, 32'h1001, 32'h1234F678, 0, 5, 0, 0);
    cycle("lbu");
    chk("lbu.dataC", WriteDataW, 32'h000000F6);

    // Link select, then the same with rd=x0
    drive(1, 1, 0, 1, 3'b000, 32'hDEAD, 0, 32'h404, 1, 0, 0);
    cycle("jal");
    chk("jal.dataC", WriteDataW, 32'h404);
    chk("jal.weC", RegWriteEnW, 1'b1);
    drive(1, 1, 0, 1, 3'b000, 32'hDEAD, 0, 32'h404, 0, 0, 0);
    cycle("jalx0");
    chk("jalx0.weC", RegWriteEnW, 1'b0);

    // Stall holds for 3 cycles with different M inputs, then stall+flush
    drive(1, 1, 0, 0, 3'b000, 32'h55, 0, 0, 7, 0, 0);
    cycle("alu");
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 3'b000, 32'h99 + i, 0, 0, 9, 1, 0);
      cycle("stall");
      chk("stall.dataC", WriteDataW, 32'h55);
      chk("stall.weC", RegWriteEnW, 1'b1);
    end
    drive(1, 1, 0, 0, 3'b000, 32'h77, 0, 0, 9, 1, 1);
    cycle("flush");
    chk("flush.validC", ValidW, 1'b0);
    chk("flush.weC", RegWriteEnW, 1'b0);

    // Misaligned LW, then aligned LW keeps the sticky flag
    drive(1, 1, 1, 0, 3'b010, 32'h102, 32'h11112222, 0, 3, 0, 0);
    cycle("mlw");
    chk("mlw.weC", RegWriteEnW, 1'b0);
    chk("mlw.misC", LoadMisalignW, 1'b1);
    drive(1, 1, 1, 0, 3'b010, 32'h100, 32'hCAFEBABE, 0, 3, 0, 0);
    cycle("lw");
    chk("lw.weC", RegWriteEnW, 1'b1);
    chk("lw.dataC", WriteDataW, 32'hCAFEBABE);
    chk("lw.misC", LoadMisalignW, 1'b1);

    // Asynchronous reset between edges while a valid op sits in WB
    drive(1, 1, 0, 0, 3'b000, 32'h1234, 0, 0, 4, 0, 0);
    cycle("pre");
    chk("pre.validC", ValidW, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rstN = 1'b0;
    #1;
    resetModel();
    chk("arst.valid", ValidW, 1'b0);
    chk("arst.we",    RegWriteEnW, 1'b0);
    chk("arst.addr",  WriteAddressW, 5'd0);
    chk("arst.data",  WriteDataW, 32'd0);
    chk("arst.misal", LoadMisalignW, 1'b0);
`ifdef RETIRE_COUNTER_EN
    chk("arst.instret", InstretW, 64'd0);
`endif
    #1 rstN = 1'b1;
    cycle("idle");

    // Retire count: 4 valid ops, 2 stalled cycles, then a bubble
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 3'b000, 32'h10 + i, 0, 0, 5'd10 + 5'(i), 0, 0);
      cycle("ret");
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle("retst");
    cycle("retst");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("retb");
`ifdef RETIRE_COUNTER_EN
    chk("ret.countC", InstretW, 64'd4);
`endif

    // Randomized traffic; the pre-edge check also catches any M->W leak
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
            f3Tab[$urandom_range(0, 5)], $urandom, $urandom, $urandom,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      #1 checkAll("rndPre");
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary plus writeback stage; sits directly downstream of the memory cycle.
- Registers the memory-cycle results, then performs load byte/halfword extraction and sign/zero extension.
- Selects the register-file write data: load data, PC+4 link, or ALU result.
- Drives the register-file write port and the forwarding unit's WB-side inputs.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_ADDR_W, 5, register address width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- StallW  input  1  hold the MEM/WB register contents
- FlushW  input  1  insert a bubble into the MEM/WB register
- ValidM  input  1  the memory-cycle slot holds a real instruction
- RegWriteM  input  1  the instruction writes rd
- MemReadM  input  1  the instruction is a load
- JtypeM  input  1  jal/jalr; rd receives PC+4
- Funct3M  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ALUOutM  input  32  ALU result / effective address
- DataMemOutM  input  32  raw word from data memory, same cycle as ALUOutM
- PCPlus4M  input  32  link value
- WriteAddressM  input  5  rd
- RegWriteEnW  output  1  register-file write enable
- WriteAddressW  output  5  register-file write address
- WriteDataW  output  32  register-file write data (also the forwarding value)
- ValidW  output  1  a valid instruction is in WB this cycle
- LoadMisalignW  output  1  sticky misaligned-load flag

Behaviour:
- Reset (reset=0, asynchronous):
  - All pipeline registers clear: ValidW=0, RegWriteEnW=0, WriteAddressW=0, WriteDataW=0, LoadMisalignW=0.
  - Takes effect immediately, mid-operation included; the in-flight instruction is discarded and not retired.
- Register update, priority on each rising clk:
  - FlushW: valid, regwrite, memread, jtype all capture 0; data fields are don't-care but held at 0. Flush beats stall when both are asserted.
  - Else StallW: all registers hold.
  - Else: capture every M input.
- Latency: exactly one cycle from M inputs to W outputs; no combinational path from M inputs to W outputs.
- Load extraction, combinational from registered fields; lane = ALUOut[1:0]:
  - LB/LBU: byte DataMemOut[8*lane+7 : 8*lane], sign- or zero-extended.
  - LH/LHU: halfword selected by ALUOut[1], sign- or zero-extended; ALUOut[0]=1 is misaligned.
  - LW: whole word; ALUOut[1:0]≠00 is misaligned.
  - Any other Funct3 with MemRead: treated as LW.
- Writeback select, in priority order: MemRead → extended load data; Jtype → PCPlus4; else ALUOut.
- Write enable: RegWriteEnW = ValidW & RegWrite & (WriteAddressW≠0) & ~misaligned.
  - When RegWriteEnW=0, WriteDataW is still driven with the selected value.
  - x0 is never written.
- Misaligned valid load:
  - The write is suppressed.
  - LoadMisalignW sets on the cycle the load sits in WB and stays 1 until reset.
- Stall: WB outputs stay stable for every stalled cycle. The register file may rewrite the same value; this is harmless and required to be idempotent.

Optional Feature:
- Macro RETIRE_COUNTER_EN.
- Defined:
  - Adds output InstretW [63:0], reset to 0.
  - Increments by 1 on each rising edge where ValidW=1 and the stage is not stalled; each instruction counts exactly once.
  - Wraps from 2^64-1 to 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- LB sign extension: ALUOutM=0x1001, DataMemOutM=0x1234F678, Funct3=000, rd=5 → next cycle WriteDataW=0xFFFFFFF6, RegWriteEnW=1, WriteAddressW=5. Repeat with LBU → 0x000000F6.
- Link select: JtypeM=1, PCPlus4M=0x00000404, ALUOutM=0xDEAD, rd=1 → WriteDataW=0x00000404. Same instruction with rd=0 → RegWriteEnW=0.
- Stall then flush: capture ALU op ALUOut=0x55, hold StallW 3 cycles → outputs constant at 0x55. Then assert StallW and FlushW together → next cycle ValidW=0, RegWriteEnW=0.
- Misaligned LW: ALUOut=0x102 → RegWriteEnW=0 and LoadMisalignW=1. A following aligned LW still writes; LoadMisalignW stays 1.
- Async reset mid-stream: drop reset between clock edges while ValidW=1 → all outputs 0 immediately, before the next edge. With RETIRE_COUNTER_EN: 4 valid unstalled instructions plus 2 stalled cycles → InstretW=4.
